// File: rtl/cr_ram1_request.sv
// cr_ram1_request: splits a RAM1 read command (start address, word count)
// into request-FIFO words of at most MAX_CHUNK words each.
module cr_ram1_request #(
  parameter int MAX_CHUNK = 15
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_len,
  output logic        cmd_ready,
  input  logic        fifo_full,
  output logic        fifo_wr,
  output logic [15:0] fifo_wdata,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for a command; cmd_ready high
  // SPLIT | emitting request words until remaining reaches zero
  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  localparam logic [7:0] MAX_C = 8'(MAX_CHUNK);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] rem_q, rem_d;
  logic       done_q, done_d;
  logic [3:0] chunk;
  logic       accept;

  // Chunk is min(remaining, MAX_CHUNK); MAX_CHUNK <= 15 so 4 bits suffice.
  always_comb begin
    chunk = (rem_q < MAX_C) ? rem_q[3:0] : MAX_C[3:0];
  end

  assign cmd_ready  = ~reset_p & (state_q == IDLE);
  assign fifo_wr    = ~reset_p & (state_q == SPLIT) & ~fifo_full;
  assign fifo_wdata = {4'b0000, chunk, addr_q};
  assign busy       = (state_q == SPLIT);
  assign done       = done_q;
  assign accept     = cmd_valid & cmd_ready;

  // Next-state: accept commands in IDLE, advance one chunk per FIFO write in SPLIT.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = SPLIT;
          end
        end
      end
      SPLIT: begin
        if (fifo_wr) begin
          addr_d = addr_q + {4'b0000, chunk};
          rem_d  = rem_q - {4'b0000, chunk};
          if (rem_q == {4'b0000, chunk}) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; address and remaining count need no reset value.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
    addr_q <= addr_d;
    rem_q  <= rem_d;
  end

endmodule

// File: tb/tb_cr_ram1_request.sv
// Testbench for cr_ram1_request: two instances (MAX_CHUNK 15 and 4) driven
// with the same stimulus and checked every cycle against a command-level model.
module tb_cr_ram1_request;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_len;
  logic        fifo_full;
  logic [1:0]  rdy, wr, bsy, dn;
  logic [15:0] wd [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cr_ram1_request #(.MAX_CHUNK(15)) dut15 (
    .clk(clk), .reset_p(reset_p), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_ready(rdy[0]), .fifo_full(fifo_full), .fifo_wr(wr[0]),
    .fifo_wdata(wd[0]), .busy(bsy[0]), .done(dn[0])
  );

  cr_ram1_request #(.MAX_CHUNK(4)) dut4 (
    .clk(clk), .reset_p(reset_p), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_ready(rdy[1]), .fifo_full(fifo_full), .fifo_wr(wr[1]),
    .fifo_wdata(wd[1]), .busy(bsy[1]), .done(dn[1])
  );

  // Command-level model: word i of a command covers addresses base+i*mc ..
  int m_base [2];
  int m_len  [2];
  int m_idx  [2];
  int m_nw   [2];
  bit m_done [2];

  logic [15:0] cap [2][16];
  int          ncap [2];

  function automatic int mcof(input int d);
    return (d == 0) ? 15 : 4;
  endfunction

  function automatic logic [15:0] exp_word(input int d);
    int rem, c, a;
    rem = m_len[d] - m_idx[d] * mcof(d);
    c   = (rem < mcof(d)) ? rem : mcof(d);
    a   = (m_base[d] + m_idx[d] * mcof(d)) % 256;
    return {4'h0, 4'(c), 8'(a)};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_idx[d] = 0; m_nw[d] = 0; m_done[d] = 1'b0;
    end
  endtask

  // One clock: check outputs at negedge, advance model, then move past the edge.
  task automatic step();
    logic act;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      act = (m_idx[d] < m_nw[d]);
      chk($sformatf("cmd_ready[%0d]", d), {15'd0, rdy[d]}, {15'd0, ~reset_p & ~act});
      chk($sformatf("busy[%0d]", d), {15'd0, bsy[d]}, {15'd0, act});
      chk($sformatf("fifo_wr[%0d]", d), {15'd0, wr[d]}, {15'd0, act & ~fifo_full & ~reset_p});
      chk($sformatf("done[%0d]", d), {15'd0, dn[d]}, {15'd0, m_done[d]});
      if (act) chk($sformatf("fifo_wdata[%0d]", d), wd[d], exp_word(d));
      if (wr[d] === 1'b1) begin
        if (ncap[d] < 16) cap[d][ncap[d]] = wd[d];
        ncap[d]++;
      end
      if (reset_p) begin
        m_idx[d] = 0; m_nw[d] = 0; m_done[d] = 1'b0;
      end else begin
        m_done[d] = 1'b0;
        if (act) begin
          if (!fifo_full) begin
            m_idx[d]++;
            if (m_idx[d] == m_nw[d]) m_done[d] = 1'b1;
          end
        end else if (cmd_valid) begin
          m_base[d] = int'(cmd_addr);
          m_len[d]  = int'(cmd_len);
          m_idx[d]  = 0;
          m_nw[d]   = (m_len[d] + mcof(d) - 1) / mcof(d);
          if (m_nw[d] == 0) m_done[d] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (((bsy != 2'b00) || (dn != 2'b00)) && t < 60) begin
      step();
      t++;
    end
    if (t >= 60) chk("drain_timeout", 16'd1, 16'd0);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] l);
    ncap[0] = 0; ncap[1] = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    step();
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  len;
    int          sel;
    int          n;
    logic [15:0] w0, w1, w2;
  } vec_t;

  vec_t vt [5];

  initial begin
    vt[0] = '{8'h10, 8'd40, 0, 3, 16'h0F10, 16'h0F1F, 16'h0A2E};
    vt[1] = '{8'hF8, 8'd20, 0, 2, 16'h0FF8, 16'h0507, 16'h0000};
    vt[2] = '{8'h00, 8'd0,  0, 0, 16'h0000, 16'h0000, 16'h0000};
    vt[3] = '{8'h00, 8'd9,  1, 3, 16'h0400, 16'h0404, 16'h0108};
    vt[4] = '{8'h00, 8'd9,  0, 1, 16'h0900, 16'h0000, 16'h0000};

    reset_p = 1'b1; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_len = 8'h00; fifo_full = 1'b0;
    ncap[0] = 0; ncap[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    reset_p = 1'b0;
    step();

    // Table-driven fixed scenarios.
    for (int v = 0; v < 5; v++) begin
      logic [15:0] ew [3];
      ew[0] = vt[v].w0; ew[1] = vt[v].w1; ew[2] = vt[v].w2;
      issue(vt[v].addr, vt[v].len);
      drain();
      chk($sformatf("vec%0d_nwords", v), 16'(ncap[vt[v].sel]), 16'(vt[v].n));
      for (int i = 0; i < vt[v].n; i++)
        chk($sformatf("vec%0d_word%0d", v, i), cap[vt[v].sel][i], ew[i]);
    end

    // FIFO full stall after the first word: second word held, then written.
    issue(8'h20, 8'd30);
    step();
    fifo_full = 1'b1;
    repeat (5) step();
    fifo_full = 1'b0;
    drain();
    chk("stall_nwords", 16'(ncap[0]), 16'd2);
    chk("stall_word0", cap[0][0], 16'h0F20);
    chk("stall_word1", cap[0][1], 16'h0F2F);

    // Reset in mid-command abandons the rest; a following command works.
    issue(8'h10, 8'd40);
    step();
    reset_p = 1'b1;
    step();
    reset_p = 1'b0;
    ncap[0] = 0; ncap[1] = 0;
    repeat (3) step();
    chk("post_reset_writes", 16'(ncap[0]), 16'd0);
    issue(8'h55, 8'd1);
    drain();
    chk("post_reset_nwords", 16'(ncap[0]), 16'd1);
    chk("post_reset_word", cap[0][0], 16'h0155);

    // Back-to-back: a new command held valid is taken in the done cycle.
    ncap[0] = 0; ncap[1] = 0;
    cmd_valid = 1'b1; cmd_addr = 8'h30; cmd_len = 8'd5;
    step();
    step();
    cmd_addr = 8'h40; cmd_len = 8'd3;
    step();
    cmd_valid = 1'b0;
    drain();
    chk("b2b_nwords", 16'(ncap[0]), 16'd2);
    chk("b2b_word1", cap[0][1], 16'h0340);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      reset_p   = ($urandom_range(0, 149) == 0);
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_addr  = 8'($urandom_range(0, 255));
      cmd_len   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 35));
      fifo_full = ($urandom_range(0, 3) == 0);
      step();
    end
    reset_p = 1'b0; cmd_valid = 1'b0; fifo_full = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
